msk_lbox_seq_unit: RTL and testbench
====================================

// Module: msk_lbox_seq_unit
// PURPOSE
//  Sequential, parametrised masked L-box layer for the Clyde-128 round. Accepts a full d-share
//  state, applies the dual (forward/inverse) L-box to every 64-bit column pair over
//  NCYC = (Nbits/64)/LB_PAR cycles and returns the shared result.
//  Handshakes on both sides. Sits between the masked S-box layer and the tweakey addition.
// PARAMETERS
//  d       2    number of shares per bit (>=2)
//  Nbits   128  unmasked state width; multiple of 64
//  LB_PAR  1    dual L-boxes instantiated per cycle; must divide Nbits/64
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input state valid
//  in_ready   out  1          unit can accept a state
//  inverse    in   1          0 = forward L-box, 1 = inverse; sampled on accept
//  state_in   in   d*Nbits    shared state, bit i shares at [d*i +: d]
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  state_out  out  d*Nbits    shared result, same layout
//  rnd        in   (d-1)*64*LB_PAR  fresh randomness (only with MSK_LBOX_REFRESH_EN)
// BEHAVIOUR
//  - FSM IDLE -> BUSY -> DONE -> IDLE. Reset: IDLE, in_ready=0 during reset then 1,
//    out_valid=0, state register and cycle counter all-zero, latched inverse=0.
//  - IDLE: in_ready=1. in_valid&in_ready loads state_in into the state register,
//    latches inverse, clears counter, goes BUSY.
//  - BUSY: in_ready=0. Each cycle the lowest d*64*LB_PAR bits pass through LB_PAR dual
//    L-boxes (x = low 32*d, y = high 32*d of each 64*d slice), the result is written back at the
//    top while the register rotates right by d*64*LB_PAR. Counter increments; at NCYC-1 -> DONE.
//  - After NCYC rotations the state is back in its original column order.
//  - DONE: out_valid=1, state_out = state register (registered, stable while stalled).
//    out_valid&out_ready -> IDLE. No in_ready in DONE (no back-to-back overlap).
//  - Latency: accept at edge k => out_valid high after edge k+NCYC.
//  - in_valid/inverse/state_in ignored outside IDLE. state_out undefined-but-stable outside DONE
//    (shows register contents; consumers qualify with out_valid).
//  - Reset asserted mid-BUSY/DONE: immediate return to IDLE, the pending result is dropped,
//    and the register is zeroed so no share data persists.
//  - Counter width clog2(NCYC) (min 1); NCYC=1 goes BUSY -> DONE after one cycle.
//  - Linear layer: every share is transformed independently; no share mixing.
// CONFIGURATION
//  MSK_LBOX_REFRESH_EN defined: the rnd port exists; each BUSY cycle after the L-box, for every
//   processed bit, shares 1..d-1 ^= r_j and share 0 ^= XOR of all r_j. The unmasked value is
//   unchanged. rnd is consumed only in BUSY cycles.
//  Undefined: no rnd port and no refresh; the output is a pure per-share L-box.
// STRUCTURE
//  - Package msk_lbox_pkg: LBOX_WORD=32, LBOX_PAIR=64, state enum {IDLE,BUSY,DONE},
//    and the NCYC/counter-width functions.
//  - Sub-module msk_lbox_bundle: combinational LB_PAR dual L-boxes on one d*64*LB_PAR slice,
//    with inverse select. The top module holds the FSM, counter, rotating register and
//    optional refresh.
// TESTING
//  Golden model = unmasked Clyde L-box/inverse; check by XOR-recombining shares.
//  1 Nbits=128,LB_PAR=1,d=2: random shared state, inverse=0 -> out_valid 2 cycles after
//    accept; recombined == lbox(x,y) per column.
//  2 Forward result fed back with inverse=1 -> recombined == original unmasked state.
//  3 All-zero sharing (state_in=0) -> state_out=0; with refresh on and rnd!=0, shares are
//    non-zero but recombine to 0.
//  4 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, state_out stable,
//    in_ready=0; in_valid pulses ignored.
//  5 rst_n pulsed low in cycle 1 of BUSY -> out_valid=0, in_ready=1 after release,
//    register=0; next transaction correct.
//  6 Sweep d in {2,3,4}, LB_PAR in {1,2}: latency == (Nbits/64)/LB_PAR and outputs match
//    the model.

Source files
------------

// File: rtl/msk_lbox_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the sequential masked L-box layer.
package msk_lbox_pkg;

    localparam int LBOX_WORD = 32;
    localparam int LBOX_PAIR = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lbox_state_e;

    // Number of BUSY cycles needed to sweep every column pair once.
    function automatic int calc_ncyc(input int nbits, input int lb_par);
        return (nbits / LBOX_PAIR) / lb_par;
    endfunction

    // Cycle counter width; a single-cycle sweep still gets a 1-bit counter.
    function automatic int calc_cnt_w(input int ncyc);
        return (ncyc <= 1) ? 1 : $clog2(ncyc);
    endfunction

endpackage

// File: rtl/msk_lbox_bundle.sv
// LB_PAR combinational dual (forward/inverse) Clyde L-boxes applied share-by-share to one
// d*64*LB_PAR slice of the interleaved shared state (bit i, share s at index D*i+s).
module msk_lbox_bundle
    import msk_lbox_pkg::*;
#(
    parameter int D      = 2,
    parameter int LB_PAR = 1
) (
    input  logic                          inverse,
    input  logic [D*LBOX_PAIR*LB_PAR-1:0] slice_in,
    output logic [D*LBOX_PAIR*LB_PAR-1:0] slice_out
);

    localparam int PAIR_W = D * LBOX_PAIR;

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        logic [63:0] dbl;
        dbl = {v, v} >> n;
        return dbl[31:0];
    endfunction

    // Returns {y', x'}.
    function automatic logic [63:0] lbox_fwd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, c, e;
        a = x ^ ror(x, 12);
        b = y ^ ror(y, 12);
        a = a ^ ror(a, 3);
        b = b ^ ror(b, 3);
        a = a ^ ror(x, 17);
        b = b ^ ror(y, 17);
        c = a ^ ror(a, 31);
        e = b ^ ror(b, 31);
        a = a ^ ror(e, 26);
        b = b ^ ror(c, 25);
        a = a ^ ror(c, 15);
        b = b ^ ror(e, 15);
        return {b, a};
    endfunction

    function automatic logic [63:0] lbox_inv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, c, e;
        a = x ^ ror(x, 25);
        b = y ^ ror(y, 25);
        c = x ^ ror(a, 31);
        e = y ^ ror(b, 31);
        c = c ^ ror(a, 20);
        e = e ^ ror(b, 20);
        a = c ^ ror(c, 31);
        b = e ^ ror(e, 31);
        c = c ^ ror(b, 26);
        e = e ^ ror(a, 25);
        a = a ^ ror(c, 17);
        b = b ^ ror(e, 17);
        return {ror(b, 16), ror(a, 16)};
    endfunction

    // The L-box is linear, so each share is de-interleaved and transformed on its own.
    for (genvar p = 0; p < LB_PAR; p++) begin : g_lbox
        for (genvar s = 0; s < D; s++) begin : g_share
            logic [31:0] x_w;
            logic [31:0] y_w;
            logic [63:0] fwd_w;
            logic [63:0] inv_w;
            logic [63:0] res_w;

            for (genvar k = 0; k < LBOX_WORD; k++) begin : g_bit
                assign x_w[k] = slice_in[p*PAIR_W + D*k + s];
                assign y_w[k] = slice_in[p*PAIR_W + D*(LBOX_WORD+k) + s];
                assign slice_out[p*PAIR_W + D*k + s]             = res_w[k];
                assign slice_out[p*PAIR_W + D*(LBOX_WORD+k) + s] = res_w[LBOX_WORD+k];
            end

            assign fwd_w = lbox_fwd(x_w, y_w);
            assign inv_w = lbox_inv(x_w, y_w);
            assign res_w = inverse ? inv_w : fwd_w;
        end
    end

endmodule

// File: rtl/msk_lbox_seq_unit.sv
// Sequential masked L-box layer: rotates the shared state through LB_PAR dual L-boxes per cycle.
// Optional feature macro: MSK_LBOX_REFRESH_EN adds the rnd port and per-cycle share refresh.
module msk_lbox_seq_unit
    import msk_lbox_pkg::*;
#(
    parameter int d      = 2,
    parameter int Nbits  = 128,
    parameter int LB_PAR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inverse,
    input  logic [d*Nbits-1:0]   state_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [d*Nbits-1:0]   state_out
`ifdef MSK_LBOX_REFRESH_EN
    ,
    input  logic [(d-1)*LBOX_PAIR*LB_PAR-1:0] rnd
`endif
);

    localparam int STATE_W   = d * Nbits;
    localparam int SLICE_W   = d * LBOX_PAIR * LB_PAR;
    localparam int PROC_BITS = LBOX_PAIR * LB_PAR;
    localparam int NCYC      = calc_ncyc(Nbits, LB_PAR);
    localparam int CNT_W     = calc_cnt_w(NCYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    lbox_state_e        state_cur;
    lbox_state_e        state_nxt;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_rot;
    logic [CNT_W-1:0]   cnt_q;
    logic               inv_q;
    logic               accept;
    logic [SLICE_W-1:0] lbox_out;
    logic [SLICE_W-1:0] slice_new;

    msk_lbox_bundle #(
        .D      (d),
        .LB_PAR (LB_PAR)
    ) u_bundle (
        .inverse   (inv_q),
        .slice_in  (state_q[SLICE_W-1:0]),
        .slice_out (lbox_out)
    );

`ifdef MSK_LBOX_REFRESH_EN
    // rnd bit for processed bit b, share j (1..d-1) sits at (d-1)*b + j-1; share 0 absorbs their XOR.
    always_comb begin
        slice_new = lbox_out;
        for (int b = 0; b < PROC_BITS; b++) begin
            for (int j = 1; j < d; j++) begin
                slice_new[d*b+j] = slice_new[d*b+j] ^ rnd[(d-1)*b + j - 1];
                slice_new[d*b]   = slice_new[d*b]   ^ rnd[(d-1)*b + j - 1];
            end
        end
    end
`else
    assign slice_new = lbox_out;
`endif

    // Processed slice re-enters at the top, so NCYC rotations restore the original column order.
    if (SLICE_W == STATE_W) begin : g_single
        assign state_rot = slice_new;
    end else begin : g_rotate
        assign state_rot = {slice_new, state_q[STATE_W-1:SLICE_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_cur <= IDLE;
        end else begin
            state_cur <= state_nxt;
        end
    end

    // Ready is gated by rst_n so nothing can be accepted while reset is held.
    always_comb begin
        state_nxt = state_cur;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_cur)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Reset wipes the share register so no masked data outlives an aborted transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            case (state_cur)
                IDLE: begin
                    if (accept) begin
                        state_q <= state_in;
                        inv_q   <= inverse;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    state_q <= state_rot;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_msk_lbox_seq_unit.sv
// Self-checking bench for msk_lbox_seq_unit: unmasked Clyde L-box reference, scoreboard queue,
// table-driven vectors on a d=2 instance plus a d/LB_PAR sweep of extra instances.
module tb_msk_lbox_seq_unit;

    localparam int NB        = 128;
    localparam int NCYC_MAIN = 2;

    typedef struct {
        logic [127:0] plain;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sweep_done = 0;
    logic sweep_go = 1'b0;
    logic sw_rst_n = 1'b0;

    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           inverse;
    logic [255:0]   state_in;
    logic           out_valid;
    logic           out_ready;
    logic [255:0]   state_out;
`ifdef MSK_LBOX_REFRESH_EN
    logic [63:0]    rnd;
`endif

    logic [127:0] sb[$];

    msk_lbox_seq_unit #(.d(2), .Nbits(NB), .LB_PAR(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inverse   (inverse),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
`ifdef MSK_LBOX_REFRESH_EN
        ,
        .rnd       (rnd)
`endif
    );

    // Reference Clyde L-box on unmasked 32-bit words, ROT32 = rotate right.
    function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] ref_lbox(input logic [31:0] x, input logic [31:0] y, input logic inv);
        logic [31:0] a, b, c, e;
        if (!inv) begin
            a = x ^ rotr(x, 12);  b = y ^ rotr(y, 12);
            a = a ^ rotr(a, 3);   b = b ^ rotr(b, 3);
            a = a ^ rotr(x, 17);  b = b ^ rotr(y, 17);
            c = a ^ rotr(a, 31);  e = b ^ rotr(b, 31);
            a = a ^ rotr(e, 26);  b = b ^ rotr(c, 25);
            a = a ^ rotr(c, 15);  b = b ^ rotr(e, 15);
        end else begin
            a = x ^ rotr(x, 25);  b = y ^ rotr(y, 25);
            c = x ^ rotr(a, 31);  e = y ^ rotr(b, 31);
            c = c ^ rotr(a, 20);  e = e ^ rotr(b, 20);
            a = c ^ rotr(c, 31);  b = e ^ rotr(e, 31);
            c = c ^ rotr(b, 26);  e = e ^ rotr(a, 25);
            a = a ^ rotr(c, 17);  b = b ^ rotr(e, 17);
            a = rotr(a, 16);      b = rotr(b, 16);
        end
        return {b, a};
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int j = 0; j < 2; j++) begin
            r[64*j +: 64] = ref_lbox(s[64*j +: 32], s[64*j+32 +: 32], inv);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] share2(input logic [127:0] p, input logic [127:0] m);
        logic [255:0] s;
        for (int i = 0; i < 128; i++) begin
            s[2*i]   = p[i] ^ m[i];
            s[2*i+1] = m[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] unshare2(input logic [255:0] s);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = s[2*i] ^ s[2*i+1];
        return r;
    endfunction

    function automatic logic [127:0] share_of(input logic [255:0] s, input int idx);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = s[2*i+idx];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [255:0] s, input logic inv, input logic [127:0] exp);
        @(negedge clk);
        check_output("accept in_ready", in_ready, 1);
        in_valid = 1'b1;
        state_in = s;
        inverse  = inv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        state_in = ~s;
        inverse  = ~inv;
        sb.push_back(exp);
    endtask

    task automatic wait_output(output logic [127:0] exp_o);
        int lat;
        lat   = 0;
        exp_o = '0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check_output("latency", lat, NCYC_MAIN);
        if (sb.size() == 0) begin
            check_output("scoreboard empty", 1, 0);
        end else begin
            exp_o = sb.pop_front();
            check_output("result", unshare2(state_out), exp_o);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin : main_test
        logic [127:0] p0, p1, m, e;
        vec_t vecs[6];

        rst_n = 1'b1; in_valid = 1'b0; inverse = 1'b0; state_in = '0; out_ready = 1'b0;
`ifdef MSK_LBOX_REFRESH_EN
        rnd = {$urandom | 32'h1, $urandom};
`endif
        #2 rst_n = 1'b0;
        #1;
        check_output("reset in_ready", in_ready, 0);
        check_output("reset out_valid", out_valid, 0);
        check_output("reset state_out", state_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        #1;
        check_output("post-reset in_ready", in_ready, 1);
        check_output("post-reset out_valid", out_valid, 0);

        p0 = rand128();
        p1 = rand128();
        vecs[0].plain = p0;                   vecs[0].inv = 1'b0; vecs[0].exp = ref_state(p0, 1'b0);
        vecs[1].plain = ref_state(p0, 1'b0);  vecs[1].inv = 1'b1; vecs[1].exp = p0;
        vecs[2].plain = p1;                   vecs[2].inv = 1'b1; vecs[2].exp = ref_state(p1, 1'b1);
        vecs[3].plain = ref_state(p1, 1'b1);  vecs[3].inv = 1'b0; vecs[3].exp = p1;
        vecs[4].plain = 128'h1;               vecs[4].inv = 1'b0; vecs[4].exp = ref_state(128'h1, 1'b0);
        vecs[5].plain = {128{1'b1}};          vecs[5].inv = 1'b1; vecs[5].exp = ref_state({128{1'b1}}, 1'b1);

        for (int v = 0; v < 6; v++) begin
            m = rand128();
            apply_stimulus(share2(vecs[v].plain, m), vecs[v].inv, vecs[v].exp);
            wait_output(e);
`ifndef MSK_LBOX_REFRESH_EN
            check_output("share1 independent", share_of(state_out, 1), ref_state(m, vecs[v].inv));
`endif
            consume();
        end

        // All-zero sharing
        apply_stimulus('0, 1'b0, '0);
        wait_output(e);
`ifdef MSK_LBOX_REFRESH_EN
        check_output("refreshed shares nonzero", (state_out != '0), 1);
`else
        check_output("zero shares", state_out, 0);
`endif
        consume();

        // DONE stall with ignored in_valid pulses
        apply_stimulus(share2(p1, rand128()), 1'b0, ref_state(p1, 1'b0));
        wait_output(e);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            state_in = {rand128(), rand128()};
            inverse  = 1'b1;
            @(negedge clk);
            check_output("stall out_valid", out_valid, 1);
            check_output("stall in_ready", in_ready, 0);
            check_output("stall result", unshare2(state_out), e);
        end
        in_valid = 1'b0;
        consume();
        repeat (3) begin
            @(negedge clk);
            check_output("after stall out_valid", out_valid, 0);
            check_output("after stall in_ready", in_ready, 1);
        end

        // Reset in first BUSY cycle drops the transaction
        apply_stimulus(share2(p0, rand128()), 1'b0, ref_state(p0, 1'b0));
        check_output("busy in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check_output("mid reset out_valid", out_valid, 0);
        check_output("mid reset state_out", state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset release in_ready", in_ready, 1);
        check_output("reset release state_out", state_out, 0);
        repeat (3) begin
            @(negedge clk);
            check_output("dropped out_valid", out_valid, 0);
        end
        apply_stimulus(share2(p0, rand128()), 1'b1, ref_state(p0, 1'b1));
        wait_output(e);
        consume();

        sweep_go = 1'b1;
        for (int i = 0; i < 3000 && sweep_done < 6; i++) @(negedge clk);
        check_output("sweep completed", sweep_done, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Parameter sweep: each instance runs a few random transactions once the main test is done.
    for (genvar gd = 2; gd <= 4; gd++) begin : g_d
        for (genvar gp = 1; gp <= 2; gp++) begin : g_p
            localparam int W = gd * NB;
            logic           s_in_valid = 1'b0;
            logic           s_in_ready;
            logic           s_inverse = 1'b0;
            logic [W-1:0]   s_state_in = '0;
            logic           s_out_valid;
            logic           s_out_ready = 1'b0;
            logic [W-1:0]   s_state_out;
`ifdef MSK_LBOX_REFRESH_EN
            logic [(gd-1)*64*gp-1:0] s_rnd = '0;
`endif

            msk_lbox_seq_unit #(.d(gd), .Nbits(NB), .LB_PAR(gp)) u_sweep (
                .clk       (clk),
                .rst_n     (sw_rst_n),
                .in_valid  (s_in_valid),
                .in_ready  (s_in_ready),
                .inverse   (s_inverse),
                .state_in  (s_state_in),
                .out_valid (s_out_valid),
                .out_ready (s_out_ready),
                .state_out (s_state_out)
`ifdef MSK_LBOX_REFRESH_EN
                ,
                .rnd       (s_rnd)
`endif
            );

            initial begin : sweep_run
                logic [127:0] p, got, e;
                logic acc;
                logic inv;
                int lat;
                wait (sweep_go);
`ifdef MSK_LBOX_REFRESH_EN
                for (int b = 0; b < (gd-1)*64*gp; b++) s_rnd[b] = 1'($urandom_range(0, 1));
`endif
                for (int t = 0; t < 3; t++) begin
                    p   = rand128();
                    inv = t[0];
                    for (int i = 0; i < 128; i++) begin
                        acc = p[i];
                        for (int j = 1; j < gd; j++) begin
                            s_state_in[gd*i+j] = 1'($urandom_range(0, 1));
                            acc = acc ^ s_state_in[gd*i+j];
                        end
                        s_state_in[gd*i] = acc;
                    end
                    e = ref_state(p, inv);
                    @(negedge clk);
                    check_output($sformatf("sweep d%0d p%0d in_ready", gd, gp), s_in_ready, 1);
                    s_in_valid = 1'b1;
                    s_inverse  = inv;
                    @(posedge clk);
                    #1;
                    s_in_valid = 1'b0;
                    lat = 0;
                    while (lat < 20) begin
                        @(posedge clk);
                        lat++;
                        @(negedge clk);
                        if (s_out_valid) break;
                    end
                    check_output($sformatf("sweep d%0d p%0d latency", gd, gp), lat, 2 / gp);
                    for (int i = 0; i < 128; i++) got[i] = ^s_state_out[gd*i +: gd];
                    check_output($sformatf("sweep d%0d p%0d result", gd, gp), got, e);
                    s_out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    s_out_ready = 1'b0;
                end
                sweep_done++;
            end
        end
    end

endmodule
